// File: rtl/rf_scoreboard.sv
// Multi-ported register file with a per-register busy scoreboard for the OoO core.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rf_scoreboard #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 32,
   parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
   parameter int READ_PORTS  = 4,
   parameter int WRITE_PORTS = 2,
   parameter int RSV_PORTS   = 2,
   parameter bit ZERO_REG    = 1'b1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]    rd_addr,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]    rd_data,
   output logic [READ_PORTS-1:0]                    rd_busy,
   input  logic [WRITE_PORTS-1:0]                   wr_en,
   input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   wr_addr,
   input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wr_data,
   input  logic [RSV_PORTS-1:0]                     rsv_en,
   input  logic [RSV_PORTS-1:0][ADDR_WIDTH-1:0]     rsv_addr,
   input  logic                                     flush,
   output logic [ADDR_WIDTH:0]                      busy_count
);

   logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_nxt;
   logic [ADDR_WIDTH:0]   count_nxt;

   // An index is usable if it names a real register other than a hardwired zero reg.
   function automatic logic idx_ok(input logic [ADDR_WIDTH-1:0] a);
      idx_ok = (a <= ADDR_WIDTH'(NUM_REGS - 1)) && !(ZERO_REG && (a == '0));
   endfunction

   // NOTE: every signal driven here gets a default before any conditional update,
   // otherwise the unassigned paths infer latches.
   always_comb begin
      regs_nxt  = regs;
      busy_nxt  = busy;
      count_nxt = '0;
      // Ascending port order lets the highest write port win on address collisions.
      for (int j = 0; j < WRITE_PORTS; j++) begin
         if (wr_en[j] && idx_ok(wr_addr[j])) begin
            regs_nxt[wr_addr[j]] = wr_data[j];
            busy_nxt[wr_addr[j]] = 1'b0;
         end
      end
      // Reservations follow writes so a new producer keeps the register busy.
      for (int r = 0; r < RSV_PORTS; r++) begin
         if (rsv_en[r] && idx_ok(rsv_addr[r])) busy_nxt[rsv_addr[r]] = 1'b1;
      end
      if (flush) busy_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) count_nxt = count_nxt + (ADDR_WIDTH + 1)'(busy_nxt[i]);
   end

   // NOTE: the storage array is reset on purpose: architectural state must read
   // zero after reset, so this cannot map onto a reset-less RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         busy       <= '0;
         busy_count <= '0;
      end else begin
         regs       <= regs_nxt;
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end

   always_comb begin
      for (int k = 0; k < READ_PORTS; k++) begin
         rd_data[k] = '0;
         rd_busy[k] = 1'b0;
         if (!rst && idx_ok(rd_addr[k])) begin
            rd_data[k] = regs[rd_addr[k]];
            rd_busy[k] = busy[rd_addr[k]];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < WRITE_PORTS; j++) begin
               if (wr_en[j] && (wr_addr[j] == rd_addr[k])) begin
                  rd_data[k] = wr_data[j];
                  rd_busy[k] = 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the register file.
module tb_rf_scoreboard;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = $clog2(NR);
   localparam int RP = 4;
   localparam int WP = 2;
   localparam int SP = 2;
   localparam bit ZR = 1'b1;

   logic                   clk;
   logic                   rst;
   logic [RP-1:0][AW-1:0]  rd_addr;
   logic [RP-1:0][DW-1:0]  rd_data;
   logic [RP-1:0]          rd_busy;
   logic [WP-1:0]          wr_en;
   logic [WP-1:0][AW-1:0]  wr_addr;
   logic [WP-1:0][DW-1:0]  wr_data;
   logic [SP-1:0]          rsv_en;
   logic [SP-1:0][AW-1:0]  rsv_addr;
   logic                   flush;
   logic [AW:0]            busy_count;

   rf_scoreboard #(
      .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .READ_PORTS(RP),
      .WRITE_PORTS(WP), .RSV_PORTS(SP), .ZERO_REG(ZR)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .flush(flush), .busy_count(busy_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests_run = 0;
   int tests_failed = 0;
   bit cmp_en = 1'b0;

   // Architectural view: register values, pending flags, number pending.
   logic [DW-1:0] m_regs [NR];
   bit            m_busy [NR];
   int            m_count;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit usable(input int a);
      return (a < NR) && !(ZR && a == 0);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_count = 0;
   endtask

   // Apply one clock edge worth of architectural effects to the model.
   task automatic model_step();
      if (rst) begin
         model_clear();
         return;
      end
      for (int j = 0; j < WP; j++)
         if (wr_en[j] && usable(int'(wr_addr[j]))) begin
            m_regs[wr_addr[j]] = wr_data[j];
            m_busy[wr_addr[j]] = 1'b0;
         end
      for (int r = 0; r < SP; r++)
         if (rsv_en[r] && usable(int'(rsv_addr[r]))) m_busy[rsv_addr[r]] = 1'b1;
      if (flush)
         for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_count = 0;
      foreach (m_busy[i]) m_count += int'(m_busy[i]);
   endtask

   task automatic expect_read(input int k, output logic [DW-1:0] d, output bit b);
      int a;
      a = int'(rd_addr[k]);
      d = '0;
      b = 1'b0;
      if (rst || !usable(a)) return;
      d = m_regs[a];
      b = m_busy[a];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < WP; j++)
         if (wr_en[j] && int'(wr_addr[j]) == a) begin
            d = wr_data[j];
            b = 1'b0;
         end
`endif
   endtask

   always @(negedge clk) begin
      logic [DW-1:0] ed;
      bit            eb;
      if (cmp_en) begin
         for (int k = 0; k < RP; k++) begin
            expect_read(k, ed, eb);
            check($sformatf("rd_data[%0d]", k), 64'(rd_data[k]), 64'(ed));
            check($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(eb));
         end
         check("busy_count", 64'(busy_count), 64'(m_count));
      end
   end

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      rsv_en = '0; rsv_addr = '0; flush = 1'b0;
   endtask

   // Clock edge consumes the currently driven inputs, then inputs return to idle.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      idle();
   endtask

   task automatic rd_check(input string name, input int a, input logic [DW-1:0] ed, input bit eb);
      rd_addr[0] = AW'(a);
      #1;
      check({name, "_data"}, 64'(rd_data[0]), 64'(ed));
      check({name, "_busy"}, 64'(rd_busy[0]), 64'(eb));
   endtask

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      idle();
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cmp_en = 1'b1;
      #1;
      check("reset_count", 64'(busy_count), 64'd0);
      check("reset_rd0", 64'(rd_data[0]), 64'd0);

      wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF;
      cycle();
      rd_check("wr5", 5, 32'hDEADBEEF, 1'b0);

      rsv_en[0] = 1'b1; rsv_addr[0] = 7;
      cycle();
      rd_check("rsv7", 7, 32'h0, 1'b1);
      check("rsv7_count", 64'(busy_count), 64'd1);
      wr_en[1] = 1'b1; wr_addr[1] = 7; wr_data[1] = 32'h11;
      cycle();
      rd_check("wb7", 7, 32'h11, 1'b0);
      check("wb7_count", 64'(busy_count), 64'd0);

      wr_en = 2'b11; wr_addr[0] = 3; wr_addr[1] = 3; wr_data[0] = 32'hA; wr_data[1] = 32'hB;
      cycle();
      rd_check("dual3", 3, 32'hB, 1'b0);
      wr_en[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'h99; rsv_en[1] = 1'b1; rsv_addr[1] = 9;
      cycle();
      rd_check("wrrsv9", 9, 32'h99, 1'b1);
      check("wrrsv9_count", 64'(busy_count), 64'd1);

      wr_en[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 32'h55; rsv_en[0] = 1'b1; rsv_addr[0] = 0;
      cycle();
      rd_check("zero", 0, 32'h0, 1'b0);
      check("zero_count", 64'(busy_count), 64'd1);

      rsv_en = 2'b11; rsv_addr[0] = 1; rsv_addr[1] = 2;
      cycle();
      rsv_en = 2'b11; rsv_addr[0] = 3; rsv_addr[1] = 4;
      cycle();
      check("rsv1to4_count", 64'(busy_count), 64'd5);
      flush = 1'b1; rsv_en[0] = 1'b1; rsv_addr[0] = 6;
      cycle();
      check("flush_count", 64'(busy_count), 64'd0);
      rd_check("flush6", 6, 32'h0, 1'b0);

      wr_en[0] = 1'b1; wr_addr[0] = 2; wr_data[0] = 32'h77;
`ifdef RF_BYPASS_EN
      rd_check("bypass2", 2, 32'h77, 1'b0);
`else
      rd_check("bypass2", 2, 32'h0, 1'b0);
`endif
      cycle();
      rd_check("after2", 2, 32'h77, 1'b0);

      // Asynchronous reset mid-cycle with a write and a reservation in flight.
      wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'h1234; rsv_en[0] = 1'b1; rsv_addr[0] = 10;
      #2 rst = 1'b1;
      model_clear();
      rd_check("arst5", 5, 32'h0, 1'b0);
      check("arst_count", 64'(busy_count), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
      rd_check("post_rst5", 5, 32'h0, 1'b0);
      rd_check("post_rst10", 10, 32'h0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < RP; k++) rd_addr[k] = AW'($urandom_range(0, NR - 1));
         for (int j = 0; j < WP; j++) begin
            wr_en[j]   = ($urandom_range(0, 2) == 0);
            wr_addr[j] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
            wr_data[j] = DW'($urandom);
         end
         for (int r = 0; r < SP; r++) begin
            rsv_en[r]   = ($urandom_range(0, 1) == 0);
            rsv_addr[r] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
         end
         flush = ($urandom_range(0, 15) == 0);
         if (n % 4 == 0) rd_addr[0] = wr_addr[WP-1];
         cycle();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
